// File: rtl/ysyx_220053_pkg.sv
// Shared definitions for the ysyx_220053 instruction fetch path: reset PC,
// fetch FSM state encoding and small address helpers.
package ysyx_220053_pkg;

    localparam int unsigned XLEN_DEF = 64;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        RESP = 2'd1,
        OUT  = 2'd2,
        NPC  = 2'd3
    } ifu_state_t;

    // Instructions are 4-byte aligned; any low-bit set in a target is a fault.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

endpackage

// File: rtl/ysyx_220053_ifu_wsel.sv
// Selects the 32-bit instruction out of a 64-bit memory word using pc[2].
module ysyx_220053_ifu_wsel (
    input  logic [63:0] data_i,
    input  logic        sel_i,
    output logic [31:0] word_o
);

    assign word_o = sel_i ? data_i[63:32] : data_i[31:0];

endmodule

// File: rtl/ysyx_220053_ifu.sv
// Instruction fetch unit for a multi-cycle core: one fetch per PC, then wait
// for the execute unit's next PC. Any dnpc outside NPC acts as a flush.
module ysyx_220053_ifu
    import ysyx_220053_pkg::*;
#(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = ysyx_220053_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            dnpc_valid,
    input  logic [XLEN-1:0] dnpc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            misalign
);

    ifu_state_t      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            drop_q, drop_d;
    logic            misalign_q, misalign_d;
    logic [31:0]     inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic            req_valid_q, req_valid_d;
    logic            inst_valid_q, inst_valid_d;
    logic            req_fire_s;
    logic            capture_s;
    logic [31:0]     word_s;

    ysyx_220053_ifu_wsel u_wsel (
        .data_i (imem_rsp_data),
        .sel_i  (pc_q[2]),
        .word_o (word_s)
    );

    assign req_fire_s = req_valid_q & imem_req_ready;

    // Next-state logic; drop marks a response already in flight that belongs to a flushed PC.
    always_comb begin
        state_d    = state_q;
        drop_d     = drop_q;
        capture_s  = 1'b0;
        pc_d       = dnpc_valid ? {dnpc[XLEN-1:2], 2'b00} : pc_q;
        misalign_d = misalign_q | (dnpc_valid & is_misaligned(dnpc[1:0]));
        case (state_q)
            REQ: begin
                if (req_fire_s) begin
                    state_d = RESP;
                    drop_d  = dnpc_valid;
                end else begin
                    state_d = REQ;
                end
            end
            RESP: begin
                if (imem_rsp_valid) begin
                    drop_d = 1'b0;
                    if (drop_q | dnpc_valid) begin
                        state_d = REQ;
                    end else begin
                        state_d   = OUT;
                        capture_s = 1'b1;
                    end
                end else if (dnpc_valid) begin
                    drop_d = 1'b1;
                end else begin
                    drop_d = drop_q;
                end
            end
            OUT: begin
                if (dnpc_valid) begin
                    state_d = REQ;
                end else if (inst_ready) begin
                    state_d = NPC;
                end else begin
                    state_d = OUT;
                end
            end
            NPC: begin
                if (dnpc_valid) begin
                    state_d = REQ;
                end else begin
                    state_d = NPC;
                end
            end
            default: begin
                state_d = REQ;
                drop_d  = 1'b0;
            end
        endcase
    end

    // Output and capture next-values, derived from the next state so outputs stay registered.
    always_comb begin
        req_valid_d  = (state_d == REQ);
        inst_valid_d = (state_d == OUT);
        if (capture_s) begin
            inst_d    = word_s;
            inst_pc_d = pc_q;
        end else begin
            inst_d    = inst_q;
            inst_pc_d = inst_pc_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= REQ;
            pc_q         <= RESET_PC;
            drop_q       <= 1'b0;
            misalign_q   <= 1'b0;
            inst_q       <= 32'h0000_0000;
            inst_pc_q    <= RESET_PC;
            req_valid_q  <= 1'b0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_q       <= drop_d;
            misalign_q   <= misalign_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            req_valid_q  <= req_valid_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_addr      = {pc_q[XLEN-1:3], 3'b000};
    assign inst_valid     = inst_valid_q;
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign misalign       = misalign_q;

endmodule

// File: tb/tb_ysyx_220053_ifu.sv
// Directed cycle-by-cycle vector bench for ysyx_220053_ifu.
module tb_ysyx_220053_ifu;

    localparam logic [63:0] Z  = 64'h0;
    localparam logic [63:0] A0 = 64'h0000_0000_8000_0000;
    localparam logic [63:0] D1 = 64'h0010_0093_0000_0413;
    localparam logic [63:0] D2 = 64'hDEAD_BEEF_0BAD_F00D;
    localparam logic [63:0] D3 = 64'h1234_5678_00A0_0513;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dnpc_valid = 1'b0;
    logic [63:0] dnpc = 64'h0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [63:0] imem_rsp_data = 64'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        misalign;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ysyx_220053_ifu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .dnpc_valid     (dnpc_valid),
        .dnpc           (dnpc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .misalign       (misalign)
    );

    typedef struct {
        logic        dv;
        logic [63:0] dn;
        logic        rdy;
        logic        rv;
        logic [63:0] rd;
        logic        ir;
        logic        e_rv;
        logic [63:0] e_addr;
        logic        e_iv;
        logic [31:0] e_inst;
        logic [63:0] e_pc;
        logic        e_mis;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic dv, input logic [63:0] dn, input logic rdy,
                                input logic rv, input logic [63:0] rd, input logic ir,
                                input logic e_rv, input logic [63:0] e_addr, input logic e_iv,
                                input logic [31:0] e_inst, input logic [63:0] e_pc,
                                input logic e_mis);
        vec_t v;
        v.dv = dv; v.dn = dn; v.rdy = rdy; v.rv = rv; v.rd = rd; v.ir = ir;
        v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_inst = e_inst;
        v.e_pc = e_pc; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, check registered outputs, then let the edge happen.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        dnpc_valid     = v.dv;
        dnpc           = v.dn;
        imem_req_ready = v.rdy;
        imem_rsp_valid = v.rv;
        imem_rsp_data  = v.rd;
        inst_ready     = v.ir;
        #1;
        check({tag, ".req_valid"}, {63'd0, imem_req_valid}, {63'd0, v.e_rv});
        if (v.e_rv) check({tag, ".imem_addr"}, imem_addr, v.e_addr);
        check({tag, ".inst_valid"}, {63'd0, inst_valid}, {63'd0, v.e_iv});
        if (v.e_iv) begin
            check({tag, ".inst"}, {32'd0, inst}, {32'd0, v.e_inst});
            check({tag, ".inst_pc"}, inst_pc, v.e_pc);
        end
        check({tag, ".misalign"}, {63'd0, misalign}, {63'd0, v.e_mis});
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".rst_req_valid"}, {63'd0, imem_req_valid}, 64'd0);
        check({tag, ".rst_inst_valid"}, {63'd0, inst_valid}, 64'd0);
        check({tag, ".rst_inst"}, {32'd0, inst}, 64'd0);
        check({tag, ".rst_misalign"}, {63'd0, misalign}, 64'd0);
    endtask

    initial begin
        // 1: first fetch, lower word
        tbl.push_back(mk(1'b0, Z, 1'b1, 1'b0, Z, 1'b0, 1'b1, A0, 1'b0, 32'h0, Z, 1'b0));
        tbl.push_back(mk(1'b0, Z, 1'b0, 1'b1, D1, 1'b0, 1'b0, Z, 1'b0, 32'h0, Z, 1'b0));
        tbl.push_back(mk(1'b0, Z, 1'b0, 1'b0, Z, 1'b1, 1'b0, Z, 1'b1, 32'h0000_0413, A0, 1'b0));
        // 2: sequential PC, upper word
        tbl.push_back(mk(1'b1, 64'h8000_0004, 1'b0, 1'b0, Z, 1'b0, 1'b0, Z, 1'b0, 32'h0, Z, 1'b0));
        tbl.push_back(mk(1'b0, Z, 1'b1, 1'b0, Z, 1'b0, 1'b1, A0, 1'b0, 32'h0, Z, 1'b0));
        tbl.push_back(mk(1'b0, Z, 1'b0, 1'b1, D1, 1'b0, 1'b0, Z, 1'b0, 32'h0, Z, 1'b0));
        tbl.push_back(mk(1'b0, Z, 1'b0, 1'b0, Z, 1'b1, 1'b0, Z, 1'b1, 32'h0010_0093, 64'h8000_0004, 1'b0));
        tbl.push_back(mk(1'b1, 64'h8000_0008, 1'b0, 1'b0, Z, 1'b0, 1'b0, Z, 1'b0, 32'h0, Z, 1'b0));
        // 3: memory not ready for 5 cycles
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1'b0, Z, 1'b0, 1'b0, Z, 1'b0, 1'b1, 64'h8000_0008, 1'b0, 32'h0, Z, 1'b0));
        tbl.push_back(mk(1'b0, Z, 1'b1, 1'b0, Z, 1'b0, 1'b1, 64'h8000_0008, 1'b0, 32'h0, Z, 1'b0));
        // 4: redirect in RESP, stale response discarded
        tbl.push_back(mk(1'b1, 64'h8000_0100, 1'b0, 1'b0, Z, 1'b0, 1'b0, Z, 1'b0, 32'h0, Z, 1'b0));
        tbl.push_back(mk(1'b0, Z, 1'b0, 1'b1, D2, 1'b0, 1'b0, Z, 1'b0, 32'h0, Z, 1'b0));
        tbl.push_back(mk(1'b0, Z, 1'b1, 1'b0, Z, 1'b0, 1'b1, 64'h8000_0100, 1'b0, 32'h0, Z, 1'b0));
        tbl.push_back(mk(1'b0, Z, 1'b0, 1'b1, D3, 1'b0, 1'b0, Z, 1'b0, 32'h0, Z, 1'b0));
        // 5: decode stalls 4 cycles, then redirect in OUT with inst_ready high
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1'b0, Z, 1'b0, 1'b0, Z, 1'b0, 1'b0, Z, 1'b1, 32'h00A0_0513, 64'h8000_0100, 1'b0));
        tbl.push_back(mk(1'b1, 64'h8000_0200, 1'b0, 1'b0, Z, 1'b1, 1'b0, Z, 1'b1, 32'h00A0_0513, 64'h8000_0100, 1'b0));
        tbl.push_back(mk(1'b0, Z, 1'b1, 1'b0, Z, 1'b0, 1'b1, 64'h8000_0200, 1'b0, 32'h0, Z, 1'b0));
        tbl.push_back(mk(1'b0, Z, 1'b0, 1'b1, D3, 1'b0, 1'b0, Z, 1'b0, 32'h0, Z, 1'b0));
        tbl.push_back(mk(1'b0, Z, 1'b0, 1'b0, Z, 1'b1, 1'b0, Z, 1'b1, 32'h00A0_0513, 64'h8000_0200, 1'b0));
        // 6: misaligned target, sticky flag
        tbl.push_back(mk(1'b1, 64'h8000_0006, 1'b0, 1'b0, Z, 1'b0, 1'b0, Z, 1'b0, 32'h0, Z, 1'b0));
        tbl.push_back(mk(1'b0, Z, 1'b1, 1'b0, Z, 1'b0, 1'b1, A0, 1'b0, 32'h0, Z, 1'b1));
        tbl.push_back(mk(1'b0, Z, 1'b0, 1'b1, D1, 1'b0, 1'b0, Z, 1'b0, 32'h0, Z, 1'b1));
        tbl.push_back(mk(1'b0, Z, 1'b0, 1'b0, Z, 1'b1, 1'b0, Z, 1'b1, 32'h0010_0093, 64'h8000_0004, 1'b1));
        tbl.push_back(mk(1'b1, 64'h8000_0010, 1'b0, 1'b0, Z, 1'b0, 1'b0, Z, 1'b0, 32'h0, Z, 1'b1));
        tbl.push_back(mk(1'b0, Z, 1'b1, 1'b0, Z, 1'b0, 1'b1, 64'h8000_0010, 1'b0, 32'h0, Z, 1'b1));
        tbl.push_back(mk(1'b0, Z, 1'b0, 1'b0, Z, 1'b0, 1'b0, Z, 1'b0, 32'h0, Z, 1'b1));

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_reset("por");
        rst_n = 1'b1;
        @(posedge clk);

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], $sformatf("v%0d", i));

        // Reset pulse while RESP; stale response during and after reset must be ignored
        @(negedge clk);
        rst_n          = 1'b0;
        dnpc_valid     = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = D2;
        inst_ready     = 1'b0;
        #1;
        check_reset("mid");
        @(negedge clk);
        rst_n = 1'b1;

        // Redirect on the same cycle the request is accepted
        apply(mk(1'b1, 64'h8000_0040, 1'b1, 1'b0, Z, 1'b0, 1'b1, A0, 1'b0, 32'h0, Z, 1'b0), "h0");
        apply(mk(1'b0, Z, 1'b0, 1'b1, D1, 1'b0, 1'b0, Z, 1'b0, 32'h0, Z, 1'b0), "h1");
        apply(mk(1'b0, Z, 1'b1, 1'b0, Z, 1'b0, 1'b1, 64'h8000_0040, 1'b0, 32'h0, Z, 1'b0), "h2");
        apply(mk(1'b0, Z, 1'b0, 1'b1, D3, 1'b0, 1'b0, Z, 1'b0, 32'h0, Z, 1'b0), "h3");
        apply(mk(1'b0, Z, 1'b0, 1'b0, Z, 1'b1, 1'b0, Z, 1'b1, 32'h00A0_0513, 64'h8000_0040, 1'b0), "h4");
        apply(mk(1'b0, Z, 1'b0, 1'b0, Z, 1'b0, 1'b0, Z, 1'b0, 32'h0, Z, 1'b0), "h5");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
